// File: rtl/hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard
//
// Producer-side companion to the EX-stage operand forwarding network.
// It keeps a small outstanding-result counter for every architectural
// register that has a long-latency write in flight. Loads and multi-cycle
// units only produce their value at writeback. The block stalls ID/issue
// while a used source operand depends on one of these registers, or on a
// load that is currently in EX. When the stall releases, the ordinary
// MEM/WB forwarding paths can always supply the operand.
//
// Parameters
//   NUM_REGS   architectural register count (x0 is never tracked)
//   CNT_W      width of each outstanding counter; saturates at 2**CNT_W-1
//
// Ports
//   clk_i            in   core clock
//   rst_ni           in   asynchronous reset, active-low
//   id_valid_i       in   instruction present in ID
//   id_rs1_addr_i    in   ID source 1 address
//   id_rs2_addr_i    in   ID source 2 address
//   id_rs1_used_i    in   instruction reads rs1
//   id_rs2_used_i    in   instruction reads rs2
//   id_rd_addr_i     in   ID destination address
//   id_rd_wren_i     in   instruction writes rd
//   id_long_lat_i    in   result only available at writeback
//   ex_rd_addr_i     in   EX destination address
//   ex_rd_wren_i     in   EX instruction writes rd
//   ex_mem_rd_i      in   EX instruction is a load
//   wb_rd_addr_i     in   WB destination address
//   wb_retire_i      in   a long-latency result is written back this cycle
//   flush_i          in   squash the ID instruction this cycle
//   stall_o          out  hold PC/IF/ID and inject a bubble into EX
//   issue_o          out  the ID instruction advances this cycle
//   pending_o        out  bit r set while cnt[r] != 0 (registered view)
//   err_o            out  sticky: retire to a zero counter, or counter overflow
//
// Handshake: id_valid_i acts as "valid" and !stall_o acts as "ready". An
// instruction transfers (issue_o=1) in the cycle where valid && ready &&
// !flush_i hold. A flushed instruction never transfers, and it never stalls.
// -----------------------------------------------------------------------------
module hazard_scoreboard #(
    parameter int NUM_REGS = 32,
    parameter int CNT_W    = 2
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                id_valid_i,
    input  logic [4:0]          id_rs1_addr_i,
    input  logic [4:0]          id_rs2_addr_i,
    input  logic                id_rs1_used_i,
    input  logic                id_rs2_used_i,
    input  logic [4:0]          id_rd_addr_i,
    input  logic                id_rd_wren_i,
    input  logic                id_long_lat_i,
    input  logic [4:0]          ex_rd_addr_i,
    input  logic                ex_rd_wren_i,
    input  logic                ex_mem_rd_i,
    input  logic [4:0]          wb_rd_addr_i,
    input  logic                wb_retire_i,
    input  logic                flush_i,
    output logic                stall_o,
    output logic                issue_o,
    output logic [NUM_REGS-1:0] pending_o,
    output logic                err_o
);

    localparam int               AW      = 5;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Outstanding long-latency writes per register. Entry 0 is held at zero.
    logic [CNT_W-1:0]    cnt_q [NUM_REGS];
    logic [CNT_W-1:0]    cnt_d [NUM_REGS];
    logic                err_q;
    logic                err_set;

    logic [NUM_REGS-1:0] retire_hit;
    logic [NUM_REGS-1:0] eff_pending;
    logic [NUM_REGS-1:0] inc_hit;

    logic                load_in_ex;
    logic                rs1_hazard;
    logic                rs2_hazard;
    logic                waw_full;
    logic                stall;
    logic                issue;
    logic                inc;

    // ------------------------------------------------------------------
    // Effective pending view. A retirement in this cycle is forwarded by
    // the WB path, so a counter at 1 that retires now already counts as
    // free. A counter at 0 can never count as pending: a stray retire is
    // an error, and it is not a reason to stall.
    // ------------------------------------------------------------------
    always_comb begin
        retire_hit  = '0;
        eff_pending = '0;
        for (int r = 1; r < NUM_REGS; r++) begin
            retire_hit[r]  = wb_retire_i && (wb_rd_addr_i == AW'(r));
            eff_pending[r] = (cnt_q[r] != '0) &&
                             !(retire_hit[r] && (cnt_q[r] == CNT_ONE));
        end
    end

    // ------------------------------------------------------------------
    // Hazard detection and issue. x0 sources never stall, because nothing
    // is ever tracked for x0 and a load into x0 carries no data.
    // ------------------------------------------------------------------
    assign load_in_ex = ex_mem_rd_i && ex_rd_wren_i && (ex_rd_addr_i != '0);

    assign rs1_hazard = id_rs1_used_i && (id_rs1_addr_i != '0) &&
                        (eff_pending[id_rs1_addr_i] ||
                         (load_in_ex && (ex_rd_addr_i == id_rs1_addr_i)));

    assign rs2_hazard = id_rs2_used_i && (id_rs2_addr_i != '0) &&
                        (eff_pending[id_rs2_addr_i] ||
                         (load_in_ex && (ex_rd_addr_i == id_rs2_addr_i)));

    // Another long-latency write to a saturated register would overflow its
    // counter. The hold is released early when that register retires this
    // cycle, because the paired inc/retire leaves the counter unchanged.
    assign waw_full = id_rd_wren_i && id_long_lat_i && (id_rd_addr_i != '0) &&
                      (cnt_q[id_rd_addr_i] == CNT_MAX) &&
                      !retire_hit[id_rd_addr_i];

    // Gating with rst_ni makes both outputs drop as soon as reset asserts,
    // even while the ID/EX inputs still show a hazard.
    assign stall = rst_ni && id_valid_i && !flush_i &&
                   (rs1_hazard || rs2_hazard || waw_full);
    assign issue = rst_ni && id_valid_i && !flush_i && !stall;
    assign inc   = issue && id_rd_wren_i && id_long_lat_i && (id_rd_addr_i != '0);

    assign stall_o = stall;
    assign issue_o = issue;

    // ------------------------------------------------------------------
    // Counter next-state. An inc and a retire to the same register cancel.
    // Overflow and underflow leave the counter alone and raise the error.
    // ------------------------------------------------------------------
    always_comb begin
        err_set = 1'b0;
        inc_hit = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            cnt_d[r] = cnt_q[r];
        end
        cnt_d[0] = '0;
        for (int r = 1; r < NUM_REGS; r++) begin
            inc_hit[r] = inc && (id_rd_addr_i == AW'(r));
            if (inc_hit[r] && retire_hit[r]) begin
                // Net zero. A retire with nothing outstanding is still bogus.
                if (cnt_q[r] == '0) begin
                    err_set = 1'b1;
                end
            end else if (inc_hit[r]) begin
                if (cnt_q[r] == CNT_MAX) begin
                    err_set = 1'b1;
                end else begin
                    cnt_d[r] = cnt_q[r] + CNT_ONE;
                end
            end else if (retire_hit[r]) begin
                if (cnt_q[r] == '0) begin
                    err_set = 1'b1;
                end else begin
                    cnt_d[r] = cnt_q[r] - CNT_ONE;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt_q[r] <= '0;
            end
            err_q <= 1'b0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
            if (err_set) begin
                err_q <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Registered views
    // ------------------------------------------------------------------
    always_comb begin
        pending_o = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            pending_o[r] = (cnt_q[r] != '0);
        end
    end

    assign err_o = err_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_hazard_scoreboard
//
// Directed bench for hazard_scoreboard. The inputs change 1 time unit after
// each rising edge. The combinational outputs are sampled 2 units later, and
// the registered view is sampled after the next edge. Each scenario task
// drives its own vectors and compares them against hand-computed values.
// -----------------------------------------------------------------------------
module tb_hazard_scoreboard;

    logic        clk_i;
    logic        rst_ni;
    logic        id_valid_i;
    logic [4:0]  id_rs1_addr_i;
    logic [4:0]  id_rs2_addr_i;
    logic        id_rs1_used_i;
    logic        id_rs2_used_i;
    logic [4:0]  id_rd_addr_i;
    logic        id_rd_wren_i;
    logic        id_long_lat_i;
    logic [4:0]  ex_rd_addr_i;
    logic        ex_rd_wren_i;
    logic        ex_mem_rd_i;
    logic [4:0]  wb_rd_addr_i;
    logic        wb_retire_i;
    logic        flush_i;
    logic        stall_o;
    logic        issue_o;
    logic [31:0] pending_o;
    logic        err_o;

    int n_cmp = 0;
    int n_mis = 0;

    // ---------------- clock / reset ----------------
    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    hazard_scoreboard #(
        .NUM_REGS (32),
        .CNT_W    (2)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .id_valid_i    (id_valid_i),
        .id_rs1_addr_i (id_rs1_addr_i),
        .id_rs2_addr_i (id_rs2_addr_i),
        .id_rs1_used_i (id_rs1_used_i),
        .id_rs2_used_i (id_rs2_used_i),
        .id_rd_addr_i  (id_rd_addr_i),
        .id_rd_wren_i  (id_rd_wren_i),
        .id_long_lat_i (id_long_lat_i),
        .ex_rd_addr_i  (ex_rd_addr_i),
        .ex_rd_wren_i  (ex_rd_wren_i),
        .ex_mem_rd_i   (ex_mem_rd_i),
        .wb_rd_addr_i  (wb_rd_addr_i),
        .wb_retire_i   (wb_retire_i),
        .flush_i       (flush_i),
        .stall_o       (stall_o),
        .issue_o       (issue_o),
        .pending_o     (pending_o),
        .err_o         (err_o)
    );

    // ---------------- driver tasks ----------------
    task automatic clear_inputs();
        id_valid_i    = 1'b0;
        id_rs1_addr_i = '0;
        id_rs2_addr_i = '0;
        id_rs1_used_i = 1'b0;
        id_rs2_used_i = 1'b0;
        id_rd_addr_i  = '0;
        id_rd_wren_i  = 1'b0;
        id_long_lat_i = 1'b0;
        ex_rd_addr_i  = '0;
        ex_rd_wren_i  = 1'b0;
        ex_mem_rd_i   = 1'b0;
        wb_rd_addr_i  = '0;
        wb_retire_i   = 1'b0;
        flush_i       = 1'b0;
    endtask

    task automatic drive_id(input logic v, input logic [4:0] rs1, input logic u1,
                            input logic [4:0] rs2, input logic u2,
                            input logic [4:0] rd, input logic wren, input logic lng);
        id_valid_i    = v;
        id_rs1_addr_i = rs1;
        id_rs1_used_i = u1;
        id_rs2_addr_i = rs2;
        id_rs2_used_i = u2;
        id_rd_addr_i  = rd;
        id_rd_wren_i  = wren;
        id_long_lat_i = lng;
    endtask

    task automatic drive_ex(input logic [4:0] rd, input logic wren, input logic mem);
        ex_rd_addr_i = rd;
        ex_rd_wren_i = wren;
        ex_mem_rd_i  = mem;
    endtask

    task automatic drive_wb(input logic [4:0] rd, input logic retire);
        wb_rd_addr_i = rd;
        wb_retire_i  = retire;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        clear_inputs();
        tick();
        tick();
        rst_ni = 1'b1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_ni = 1'b0;
        clear_inputs();
        drive_id(1, 5, 1, 0, 0, 0, 0, 0);
        drive_ex(5, 1, 1);
        settle();
        n_cmp++; if (stall_o !== 1'b0) begin n_mis++; $display("FAIL reset_stall: got %b want 0", stall_o); end
        n_cmp++; if (issue_o !== 1'b0) begin n_mis++; $display("FAIL reset_issue: got %b want 0", issue_o); end
        n_cmp++; if (pending_o !== 32'h0) begin n_mis++; $display("FAIL reset_pending: got %h want 0", pending_o); end
        n_cmp++; if (err_o !== 1'b0) begin n_mis++; $display("FAIL reset_err: got %b want 0", err_o); end
        tick();
        tick();
        rst_ni = 1'b1;
        settle();
        n_cmp++; if (stall_o !== 1'b1) begin n_mis++; $display("FAIL reset_release_stall: got %b want 1", stall_o); end
        clear_inputs();
    endtask

    task automatic test_load_use();
        do_reset();
        drive_id(1, 5, 1, 0, 0, 0, 0, 0);
        drive_ex(5, 1, 1);
        settle();
        n_cmp++; if (stall_o !== 1'b1) begin n_mis++; $display("FAIL lu_stall: got %b want 1", stall_o); end
        n_cmp++; if (issue_o !== 1'b0) begin n_mis++; $display("FAIL lu_issue0: got %b want 0", issue_o); end
        tick();
        drive_ex(0, 0, 0);
        settle();
        n_cmp++; if (stall_o !== 1'b0) begin n_mis++; $display("FAIL lu_release_stall: got %b want 0", stall_o); end
        n_cmp++; if (issue_o !== 1'b1) begin n_mis++; $display("FAIL lu_release_issue: got %b want 1", issue_o); end
        tick();
        drive_id(1, 0, 0, 5, 1, 0, 0, 0);
        drive_ex(5, 1, 1);
        settle();
        n_cmp++; if (stall_o !== 1'b1) begin n_mis++; $display("FAIL lu_rs2_stall: got %b want 1", stall_o); end
        tick();
        drive_id(1, 5, 0, 5, 0, 0, 0, 0);
        settle();
        n_cmp++; if (issue_o !== 1'b1) begin n_mis++; $display("FAIL lu_unused_issue: got %b want 1", issue_o); end
        tick();
        drive_id(1, 5, 1, 0, 0, 0, 0, 0);
        drive_ex(5, 1, 0);
        settle();
        n_cmp++; if (stall_o !== 1'b0) begin n_mis++; $display("FAIL lu_not_load: got %b want 0", stall_o); end
        tick();
        drive_ex(5, 0, 1);
        settle();
        n_cmp++; if (stall_o !== 1'b0) begin n_mis++; $display("FAIL lu_no_wren: got %b want 0", stall_o); end
        tick();
        drive_id(0, 5, 1, 0, 0, 0, 0, 0);
        drive_ex(5, 1, 1);
        settle();
        n_cmp++; if ({stall_o, issue_o} !== 2'b00) begin n_mis++; $display("FAIL lu_invalid: got %b want 00", {stall_o, issue_o}); end
        n_cmp++; if (pending_o !== 32'h0) begin n_mis++; $display("FAIL lu_pending: got %h want 0", pending_o); end
        clear_inputs();
    endtask

    task automatic test_long_raw();
        do_reset();
        drive_id(1, 0, 0, 0, 0, 7, 1, 1);
        settle();
        n_cmp++; if (issue_o !== 1'b1) begin n_mis++; $display("FAIL raw_issue7: got %b want 1", issue_o); end
        n_cmp++; if (pending_o !== 32'h0) begin n_mis++; $display("FAIL raw_pending_early: got %h want 0", pending_o); end
        tick();
        drive_id(1, 7, 1, 0, 0, 8, 1, 0);
        settle();
        n_cmp++; if (pending_o !== 32'h0000_0080) begin n_mis++; $display("FAIL raw_pending7: got %h want 00000080", pending_o); end
        n_cmp++; if (stall_o !== 1'b1) begin n_mis++; $display("FAIL raw_stall_a: got %b want 1", stall_o); end
        n_cmp++; if (issue_o !== 1'b0) begin n_mis++; $display("FAIL raw_issue_held: got %b want 0", issue_o); end
        tick();
        drive_id(1, 0, 0, 7, 1, 8, 1, 0);
        settle();
        n_cmp++; if (stall_o !== 1'b1) begin n_mis++; $display("FAIL raw_stall_rs2: got %b want 1", stall_o); end
        tick();
        drive_id(1, 6, 1, 0, 0, 8, 1, 0);
        settle();
        n_cmp++; if (stall_o !== 1'b0) begin n_mis++; $display("FAIL raw_indep: got %b want 0", stall_o); end
        tick();
        drive_id(1, 7, 1, 0, 0, 8, 1, 0);
        drive_wb(7, 1);
        settle();
        n_cmp++; if (stall_o !== 1'b0) begin n_mis++; $display("FAIL raw_bypass_stall: got %b want 0", stall_o); end
        n_cmp++; if (issue_o !== 1'b1) begin n_mis++; $display("FAIL raw_bypass_issue: got %b want 1", issue_o); end
        tick();
        clear_inputs();
        settle();
        n_cmp++; if (pending_o !== 32'h0) begin n_mis++; $display("FAIL raw_pending_clr: got %h want 0", pending_o); end
        n_cmp++; if (err_o !== 1'b0) begin n_mis++; $display("FAIL raw_err: got %b want 0", err_o); end
    endtask

    task automatic test_x0();
        do_reset();
        drive_id(1, 0, 0, 0, 0, 0, 1, 1);
        settle();
        n_cmp++; if (issue_o !== 1'b1) begin n_mis++; $display("FAIL x0_issue: got %b want 1", issue_o); end
        tick();
        drive_id(1, 0, 1, 0, 1, 0, 1, 1);
        drive_ex(0, 1, 1);
        settle();
        n_cmp++; if (stall_o !== 1'b0) begin n_mis++; $display("FAIL x0_stall: got %b want 0", stall_o); end
        n_cmp++; if (pending_o !== 32'h0) begin n_mis++; $display("FAIL x0_pending: got %h want 0", pending_o); end
        tick();
        clear_inputs();
        drive_wb(0, 1);
        tick();
        clear_inputs();
        settle();
        n_cmp++; if (err_o !== 1'b0) begin n_mis++; $display("FAIL x0_retire_err: got %b want 0", err_o); end
        n_cmp++; if (pending_o !== 32'h0) begin n_mis++; $display("FAIL x0_pending_end: got %h want 0", pending_o); end
    endtask

    task automatic test_simul_inc_retire();
        do_reset();
        drive_id(1, 0, 0, 0, 0, 3, 1, 1);
        tick();
        drive_wb(3, 1);
        settle();
        n_cmp++; if (issue_o !== 1'b1) begin n_mis++; $display("FAIL sim_issue: got %b want 1", issue_o); end
        tick();
        clear_inputs();
        settle();
        n_cmp++; if (pending_o !== 32'h0000_0008) begin n_mis++; $display("FAIL sim_pending3: got %h want 00000008", pending_o); end
        drive_id(1, 0, 0, 0, 0, 10, 1, 1);
        drive_wb(3, 1);
        tick();
        clear_inputs();
        settle();
        n_cmp++; if (pending_o !== 32'h0000_0400) begin n_mis++; $display("FAIL sim_diff_regs: got %h want 00000400", pending_o); end
        drive_wb(10, 1);
        tick();
        clear_inputs();
        settle();
        n_cmp++; if (pending_o !== 32'h0) begin n_mis++; $display("FAIL sim_pending_end: got %h want 0", pending_o); end
        n_cmp++; if (err_o !== 1'b0) begin n_mis++; $display("FAIL sim_err: got %b want 0", err_o); end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive_id(1, 0, 0, 0, 0, 9, 1, 1);
            settle();
            n_cmp++; if (issue_o !== 1'b1) begin n_mis++; $display("FAIL sat_issue%0d: got %b want 1", i, issue_o); end
            tick();
        end
        settle();
        n_cmp++; if (stall_o !== 1'b1) begin n_mis++; $display("FAIL sat_waw_stall: got %b want 1", stall_o); end
        n_cmp++; if (pending_o !== 32'h0000_0200) begin n_mis++; $display("FAIL sat_pending9: got %h want 00000200", pending_o); end
        tick();
        settle();
        n_cmp++; if (stall_o !== 1'b1) begin n_mis++; $display("FAIL sat_waw_hold: got %b want 1", stall_o); end
        tick();
        drive_wb(9, 1);
        settle();
        n_cmp++; if (issue_o !== 1'b1) begin n_mis++; $display("FAIL sat_release: got %b want 1", issue_o); end
        tick();
        // count now 3: three retires, bypass only frees the read on the last
        drive_id(1, 9, 1, 0, 0, 0, 0, 0);
        drive_wb(9, 1);
        settle();
        n_cmp++; if (stall_o !== 1'b1) begin n_mis++; $display("FAIL sat_rd_c3: got %b want 1", stall_o); end
        tick();
        settle();
        n_cmp++; if (stall_o !== 1'b1) begin n_mis++; $display("FAIL sat_rd_c2: got %b want 1", stall_o); end
        tick();
        settle();
        n_cmp++; if (stall_o !== 1'b0) begin n_mis++; $display("FAIL sat_rd_c1: got %b want 0", stall_o); end
        tick();
        clear_inputs();
        settle();
        n_cmp++; if (pending_o !== 32'h0) begin n_mis++; $display("FAIL sat_pending_end: got %h want 0", pending_o); end
        n_cmp++; if (err_o !== 1'b0) begin n_mis++; $display("FAIL sat_err: got %b want 0", err_o); end
    endtask

    task automatic test_flush();
        do_reset();
        drive_id(1, 0, 0, 0, 0, 12, 1, 1);
        flush_i = 1'b1;
        settle();
        n_cmp++; if ({stall_o, issue_o} !== 2'b00) begin n_mis++; $display("FAIL fl_no_issue: got %b want 00", {stall_o, issue_o}); end
        tick();
        drive_id(1, 5, 1, 0, 0, 0, 0, 0);
        drive_ex(5, 1, 1);
        settle();
        n_cmp++; if (pending_o !== 32'h0) begin n_mis++; $display("FAIL fl_no_inc: got %h want 0", pending_o); end
        n_cmp++; if (stall_o !== 1'b0) begin n_mis++; $display("FAIL fl_lu_stall: got %b want 0", stall_o); end
        tick();
        clear_inputs();
        drive_id(1, 0, 0, 0, 0, 13, 1, 1);
        tick();
        clear_inputs();
        flush_i = 1'b1;
        tick();
        settle();
        n_cmp++; if (pending_o !== 32'h0000_2000) begin n_mis++; $display("FAIL fl_keeps_cnt: got %h want 00002000", pending_o); end
        drive_wb(13, 1);
        tick();
        clear_inputs();
        settle();
        n_cmp++; if (pending_o !== 32'h0) begin n_mis++; $display("FAIL fl_retire: got %h want 0", pending_o); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        drive_id(1, 0, 0, 0, 0, 2, 1, 1);
        tick();
        drive_id(1, 0, 0, 0, 0, 11, 1, 1);
        settle();
        n_cmp++; if (pending_o !== 32'h0000_0004) begin n_mis++; $display("FAIL b2b_pending2: got %h want 00000004", pending_o); end
        n_cmp++; if (issue_o !== 1'b1) begin n_mis++; $display("FAIL b2b_issue11: got %b want 1", issue_o); end
        tick();
        drive_id(1, 2, 1, 11, 1, 0, 0, 0);
        drive_wb(2, 1);
        settle();
        n_cmp++; if (pending_o !== 32'h0000_0804) begin n_mis++; $display("FAIL b2b_pending_both: got %h want 00000804", pending_o); end
        n_cmp++; if (stall_o !== 1'b1) begin n_mis++; $display("FAIL b2b_stall11: got %b want 1", stall_o); end
        tick();
        drive_wb(11, 1);
        settle();
        n_cmp++; if (issue_o !== 1'b1) begin n_mis++; $display("FAIL b2b_issue: got %b want 1", issue_o); end
        n_cmp++; if (pending_o !== 32'h0000_0800) begin n_mis++; $display("FAIL b2b_pending11: got %h want 00000800", pending_o); end
        tick();
        clear_inputs();
        settle();
        n_cmp++; if (pending_o !== 32'h0) begin n_mis++; $display("FAIL b2b_pending_end: got %h want 0", pending_o); end
    endtask

    task automatic test_error_reset();
        do_reset();
        drive_wb(4, 1);
        tick();
        clear_inputs();
        settle();
        n_cmp++; if (err_o !== 1'b1) begin n_mis++; $display("FAIL err_set: got %b want 1", err_o); end
        n_cmp++; if (pending_o !== 32'h0) begin n_mis++; $display("FAIL err_cnt_stays0: got %h want 0", pending_o); end
        tick();
        tick();
        settle();
        n_cmp++; if (err_o !== 1'b1) begin n_mis++; $display("FAIL err_sticky: got %b want 1", err_o); end
        drive_id(1, 0, 0, 0, 0, 6, 1, 1);
        tick();
        drive_id(1, 6, 1, 0, 0, 0, 0, 0);
        drive_ex(6, 1, 1);
        settle();
        n_cmp++; if (stall_o !== 1'b1) begin n_mis++; $display("FAIL err_mid_stall: got %b want 1", stall_o); end
        #1;
        rst_ni = 1'b0;
        #1;
        n_cmp++; if ({stall_o, issue_o, err_o} !== 3'b000) begin n_mis++; $display("FAIL async_rst_outs: got %b want 000", {stall_o, issue_o, err_o}); end
        n_cmp++; if (pending_o !== 32'h0) begin n_mis++; $display("FAIL async_rst_pending: got %h want 0", pending_o); end
        tick();
        drive_ex(0, 0, 0);
        rst_ni = 1'b1;
        settle();
        n_cmp++; if (stall_o !== 1'b0) begin n_mis++; $display("FAIL post_rst_stall: got %b want 0", stall_o); end
        n_cmp++; if (issue_o !== 1'b1) begin n_mis++; $display("FAIL post_rst_issue: got %b want 1", issue_o); end
        clear_inputs();
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        rst_ni = 1'b0;
        clear_inputs();
        test_reset();
        test_load_use();
        test_long_raw();
        test_x0();
        test_simul_inc_retire();
        test_saturation();
        test_flush();
        test_back_to_back();
        test_error_reset();
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
